// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bundle: redirect inputs, IMEM request/response and the decode handshake.
// master = fetch controller side, slave = surrounding core / memory side.
interface ifu_fetch_ctrl_if #(
    parameter int CPU_WIDTH = 64
);
    logic                 i_trap_valid;
    logic [CPU_WIDTH-1:0] i_trap_pc;
    logic                 i_brch_valid;
    logic [CPU_WIDTH-1:0] i_brch_pc;
    logic                 o_imem_req;
    logic [CPU_WIDTH-1:0] o_imem_addr;
    logic                 i_imem_gnt;
    logic                 i_imem_rvalid;
    logic [31:0]          i_imem_rdata;
    logic                 o_inst_valid;
    logic [31:0]          o_inst;
    logic [CPU_WIDTH-1:0] o_inst_pc;
    logic                 i_id_ready;
    logic [CPU_WIDTH-1:0] o_pc;

    modport master (
        input  i_trap_valid, i_trap_pc, i_brch_valid, i_brch_pc,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_id_ready,
        output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_pc
    );

    modport slave (
        output i_trap_valid, i_trap_pc, i_brch_valid, i_brch_pc,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_id_ready,
        input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_pc
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one IMEM fetch in flight, drops stale
// responses after a redirect and hands instructions to decode via valid/ready.
module ifu_fetch_ctrl #(
    parameter int                   CPU_WIDTH = 64,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    ifu_fetch_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CPU_WIDTH-1:0] pc_q;
    logic [CPU_WIDTH-1:0] pc_d;
    logic [CPU_WIDTH-1:0] inst_pc_q;
    logic [31:0]          inst_q;
    logic                 redir;
    logic [CPU_WIDTH-1:0] redir_pc;
    logic                 capture;
    logic                 advance;

    function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] pc);
        return {pc[CPU_WIDTH-1:2], 2'b00};
    endfunction

    // Trap/mret outranks a branch resolved in the same cycle.
    always_comb begin
        redir    = bus.i_trap_valid | bus.i_brch_valid;
        redir_pc = align_pc(bus.i_trap_valid ? bus.i_trap_pc : bus.i_brch_pc);
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.i_imem_gnt) begin
                    state_d = redir ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (bus.i_imem_rvalid) begin
                    if (redir) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                        capture = 1'b1;
                    end
                end else if (redir) begin
                    state_d = DROP;
                end
            end
            // A granted fetch cannot be cancelled; its response must be absorbed first.
            DROP: begin
                if (bus.i_imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redir) begin
                    state_d = REQ;
                end else if (bus.i_id_ready) begin
                    state_d = REQ;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (redir) begin
            pc_d = redir_pc;
        end else if (advance) begin
            pc_d = pc_q + CPU_WIDTH'(4);
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                inst_q    <= bus.i_imem_rdata;
                inst_pc_q <= pc_q;
            end
        end
    end

    // Outputs decode from registered state only, so IMEM inputs never reach o_imem_req.
    assign bus.o_imem_req   = (state_q == REQ);
    assign bus.o_imem_addr  = pc_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_inst_valid = (state_q == HOLD);
    assign bus.o_inst       = inst_q;
    assign bus.o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios followed by random traffic, all compared
// each cycle against a transaction-level model of the fetch rules.
module tb_ifu_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl_if #(.CPU_WIDTH(64)) bus ();

    ifu_fetch_ctrl #(.CPU_WIDTH(64), .RESET_PC(RST_PC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Model: a fetch is either being asked for, in flight (possibly stale), or held for decode.
    logic [63:0] m_pc    = RST_PC;
    logic [31:0] m_inst  = '0;
    logic [63:0] m_ipc   = '0;
    bit          m_idle  = 1'b1;
    bit          m_out   = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_hold  = 1'b0;

    task automatic model_step();
        bit          redir;
        bit          asking;
        logic [63:0] tgt;
        redir = bus.i_trap_valid | bus.i_brch_valid;
        tgt   = bus.i_trap_valid ? bus.i_trap_pc : bus.i_brch_pc;
        tgt[1:0] = 2'b00;
        if (!rst_n) begin
            m_pc = RST_PC; m_inst = '0; m_ipc = '0;
            m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
            return;
        end
        asking = !m_idle && !m_out && !m_hold;
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (asking) begin
            if (bus.i_imem_gnt) begin
                m_out   = 1'b1;
                m_stale = redir;
            end
        end else if (m_out) begin
            if (bus.i_imem_rvalid) begin
                if (!m_stale && !redir) begin
                    m_hold = 1'b1;
                    m_inst = bus.i_imem_rdata;
                    m_ipc  = m_pc;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (redir) begin
                m_stale = 1'b1;
            end
        end else if (m_hold) begin
            if (!redir && bus.i_id_ready) m_pc = m_pc + 64'd4;
            if (redir || bus.i_id_ready) m_hold = 1'b0;
        end
        if (redir) m_pc = tgt;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("req",   {63'b0, bus.o_imem_req},   {63'b0, (!m_idle && !m_out && !m_hold)});
        chk("addr",  bus.o_imem_addr,           m_pc);
        chk("pc",    bus.o_pc,                  m_pc);
        chk("valid", {63'b0, bus.o_inst_valid}, {63'b0, m_hold});
        chk("inst",  {32'b0, bus.o_inst},       {32'b0, m_inst});
        chk("ipc",   bus.o_inst_pc,             m_ipc);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic drv(input bit tv, input logic [63:0] tp, input bit bv, input logic [63:0] bp,
                       input bit g, input bit rv, input bit rdy);
        bus.i_trap_valid  = tv;
        bus.i_trap_pc     = tp;
        bus.i_brch_valid  = bv;
        bus.i_brch_pc     = bp;
        bus.i_imem_gnt    = g;
        bus.i_imem_rvalid = rv;
        bus.i_imem_rdata  = $urandom;
        bus.i_id_ready    = rdy;
    endtask

    // Memory that grants immediately and answers the cycle after the grant.
    task automatic auto_step(input bit rdy);
        drv(1'b0, '0, 1'b0, '0, 1'b1, m_out, rdy);
        step();
    endtask

    function automatic logic [63:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            2:       return {$urandom, $urandom};
            default: return 64'h8000_0000 + 64'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        drv(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_req",   {63'b0, bus.o_imem_req},   64'd0);
        chk("rst_pc",    bus.o_pc,                  RST_PC);
        chk("rst_valid", {63'b0, bus.o_inst_valid}, 64'd0);
        chk("rst_inst",  {32'b0, bus.o_inst},       64'd0);
        chk("rst_ipc",   bus.o_inst_pc,             64'd0);

        rst_n = 1'b1;
        auto_step(1'b1);
        chk("first_req",  {63'b0, bus.o_imem_req}, 64'd1);
        chk("first_addr", bus.o_imem_addr,         64'h8000_0000);
        auto_step(1'b1);
        auto_step(1'b1);
        chk("seq0_valid", {63'b0, bus.o_inst_valid}, 64'd1);
        chk("seq0_ipc",   bus.o_inst_pc,             64'h8000_0000);
        auto_step(1'b1);
        chk("seq1_addr",  bus.o_imem_addr,           64'h8000_0004);
        auto_step(1'b1);
        auto_step(1'b1);
        chk("seq1_ipc",   bus.o_inst_pc,             64'h8000_0004);
        auto_step(1'b1);
        chk("seq2_addr",  bus.o_imem_addr,           64'h8000_0008);

        auto_step(1'b0);
        auto_step(1'b0);
        for (int i = 0; i < 5; i++) begin
            auto_step(1'b0);
            chk("stall_valid", {63'b0, bus.o_inst_valid}, 64'd1);
            chk("stall_ipc",   bus.o_inst_pc,             64'h8000_0008);
            chk("stall_req",   {63'b0, bus.o_imem_req},   64'd0);
        end
        auto_step(1'b1);
        chk("release_addr", bus.o_imem_addr, 64'h8000_000C);

        auto_step(1'b1);
        drv(1'b0, '0, 1'b1, 64'h8000_0100, 1'b1, 1'b0, 1'b1);
        step();
        chk("wait_redir_req", {63'b0, bus.o_imem_req}, 64'd0);
        chk("wait_redir_pc",  bus.o_pc,                64'h8000_0100);
        drv(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step();
        chk("stale_valid", {63'b0, bus.o_inst_valid}, 64'd0);
        chk("stale_addr",  bus.o_imem_addr,           64'h8000_0100);

        auto_step(1'b0);
        auto_step(1'b0);
        chk("hold_valid", {63'b0, bus.o_inst_valid}, 64'd1);
        drv(1'b1, 64'h8000_0200, 1'b1, 64'h8000_0100, 1'b1, 1'b0, 1'b1);
        step();
        chk("trap_win_valid", {63'b0, bus.o_inst_valid}, 64'd0);
        chk("trap_win_addr",  bus.o_imem_addr,           64'h8000_0200);

        drv(1'b0, '0, 1'b1, 64'h8000_0300, 1'b1, 1'b0, 1'b1);
        step();
        chk("req_gnt_redir_req", {63'b0, bus.o_imem_req}, 64'd0);
        drv(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step();
        chk("req_gnt_stale_valid", {63'b0, bus.o_inst_valid}, 64'd0);
        chk("req_gnt_new_addr",    bus.o_imem_addr,           64'h8000_0300);
        drv(1'b0, '0, 1'b1, 64'h8000_0400, 1'b0, 1'b0, 1'b1);
        step();
        chk("req_nognt_req",  {63'b0, bus.o_imem_req}, 64'd1);
        chk("req_nognt_addr", bus.o_imem_addr,         64'h8000_0400);

        drv(1'b0, '0, 1'b1, 64'h8000_0103, 1'b0, 1'b0, 1'b1);
        step();
        chk("align_addr", bus.o_imem_addr, 64'h8000_0100);
        auto_step(1'b1);
        auto_step(1'b1);
        chk("align_ipc",  bus.o_inst_pc,   64'h8000_0100);
        auto_step(1'b1);
        chk("align_next", bus.o_imem_addr, 64'h8000_0104);

        drv(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk("wrap_addr", bus.o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        auto_step(1'b1);
        auto_step(1'b1);
        chk("wrap_ipc",  bus.o_inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
        auto_step(1'b1);
        chk("wrap_next", bus.o_imem_addr, 64'h0);

        auto_step(1'b1);
        rst_n = 1'b0;
        drv(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("midrst_req", {63'b0, bus.o_imem_req}, 64'd0);
        chk("midrst_pc",  bus.o_pc,                RST_PC);
        rst_n = 1'b1;
        auto_step(1'b1);
        chk("midrst_first", bus.o_imem_addr, RST_PC);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drv($urandom_range(0, 19) == 0, rand_target(),
                $urandom_range(0, 9) == 0, rand_target(),
                $urandom_range(0, 9) < 6,
                m_out && ($urandom_range(0, 9) < 5),
                $urandom_range(0, 1) == 1);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
